// File: rtl/punc_mmio_console_pkg.sv
// Shared constants for the LC3 console responder: device addresses, TX states, status bit positions.
// Pure declarations; no logic or timing of its own.
package punc_mmio_console_pkg;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  localparam int KBSR_READY_BIT = 15;
  localparam int KBSR_IE_BIT    = 14;
  localparam int DSR_READY_BIT  = 15;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] kbsr_word(input logic not_empty, input logic ie);
    logic [15:0] w;
    w = '0;
    w[KBSR_READY_BIT] = not_empty;
    w[KBSR_IE_BIT]    = ie;
    return w;
  endfunction

endpackage

// File: rtl/punc_mmio_console_if.sv
// Datapath-side bus of the console: load/store ports, keyboard valid/ready input, serial and irq outputs.
// Bundles signals only; master is the datapath/keyboard side, slave is the console.
interface punc_mmio_console_if;
  logic [15:0] r_addr;
  logic        rd_en;
  logic [15:0] r_data;
  logic        hit_r;
  logic [15:0] w_addr;
  logic [15:0] w_data;
  logic        w_en;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        tx;
  logic        irq;

  modport master (
    output r_addr, rd_en, w_addr, w_data, w_en, kb_valid, kb_data,
    input  r_data, hit_r, kb_ready, tx, irq
  );

  modport slave (
    input  r_addr, rd_en, w_addr, w_data, w_en, kb_valid, kb_data,
    output r_data, hit_r, kb_ready, tx, irq
  );
endinterface

// File: rtl/punc_uart_tx.sv
// 8N1 serial transmitter: frame starts the cycle after i_start, 10*CLKS_PER_BIT cycles long.
// No backpressure; i_start is ignored unless o_idle is high.
module punc_uart_tx
  import punc_mmio_console_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_idle
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
    end
  end

  // Baud counter reloads at every bit boundary, so each state lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_tick      = (r_cnt == LAST);
    o_tx        = 1'b1;
    o_idle      = 1'b0;
    case (r_state)
      TX_IDLE: begin
        o_idle = 1'b1;
        if (i_start) begin
          w_state_nxt = TX_START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_byte_nxt  = i_byte;
        end
      end
      TX_START: begin
        o_tx = 1'b0;
        w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
        if (w_tick) w_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        o_tx = r_byte[r_bit];
        w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
        if (w_tick) begin
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = TX_STOP;
        end
      end
      TX_STOP: begin
        w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
        if (w_tick) w_state_nxt = TX_IDLE;
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/punc_mmio_console.sv
// LC3 console at KBSR/KBDR/DSR/DDR: combinational reads, keyboard FIFO, 8N1 display output.
// kb_ready drops when the FIFO is full; DDR writes while busy are dropped. Option: PUNC_CONSOLE_IRQ_EN.
module punc_mmio_console
  import punc_mmio_console_pkg::*;
#(
  parameter logic [15:0] KBSR_ADDR     = ADDR_KBSR,
  parameter logic [15:0] KBDR_ADDR     = ADDR_KBDR,
  parameter logic [15:0] DSR_ADDR      = ADDR_DSR,
  parameter logic [15:0] DDR_ADDR      = ADDR_DDR,
  parameter int          KB_FIFO_DEPTH = 4,
  parameter int          CLKS_PER_BIT  = 16
) (
  input logic clk,
  input logic rst,
  punc_mmio_console_if.slave bus
);

  localparam int PW = $clog2(KB_FIFO_DEPTH);

  logic [7:0]    r_mem [KB_FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          w_empty, w_full, w_push, w_pop;
  logic          w_ddr_wr, w_tx_idle, w_ie;
  logic          w_unused_wdata;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (PW+1)'(KB_FIFO_DEPTH));
  assign w_push       = bus.kb_valid && !w_full;
  assign w_pop        = bus.rd_en && (bus.r_addr == KBDR_ADDR) && !w_empty;
  assign bus.kb_ready = !w_full;
  assign w_ddr_wr     = bus.w_en && (bus.w_addr == DDR_ADDR) && w_tx_idle;
  assign w_unused_wdata = &bus.w_data[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.kb_data;
  end

`ifdef PUNC_CONSOLE_IRQ_EN
  logic r_ie, r_irq;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (bus.w_en && (bus.w_addr == KBSR_ADDR)) r_ie <= bus.w_data[KBSR_IE_BIT];
      r_irq <= r_ie && !w_empty;
    end
  end
  assign w_ie    = r_ie;
  assign bus.irq = r_irq;
`else
  assign w_ie    = 1'b0;
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    bus.r_data = '0;
    bus.hit_r  = 1'b0;
    case (bus.r_addr)
      KBSR_ADDR: begin
        bus.hit_r  = 1'b1;
        bus.r_data = kbsr_word(!w_empty, w_ie);
      end
      KBDR_ADDR: begin
        bus.hit_r  = 1'b1;
        bus.r_data = {8'h00, (w_empty ? 8'h00 : r_mem[r_rptr])};
      end
      DSR_ADDR: begin
        bus.hit_r  = 1'b1;
        bus.r_data[DSR_READY_BIT] = w_tx_idle;
      end
      DDR_ADDR: bus.hit_r = 1'b1;
      default: ;
    endcase
  end

  punc_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (w_ddr_wr),
    .i_byte  (bus.w_data[7:0]),
    .o_tx    (bus.tx),
    .o_idle  (w_tx_idle)
  );

endmodule

// File: tb/tb_punc_mmio_console.sv
// Directed + randomized bench for punc_mmio_console against a queue-based console model.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_punc_mmio_console;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [15:0] A_KBSR = 16'hFE00;
  localparam logic [15:0] A_KBDR = 16'hFE02;
  localparam logic [15:0] A_DSR  = 16'hFE04;
  localparam logic [15:0] A_DDR  = 16'hFE06;

  logic clk = 1'b0;
  logic rst;
  int   n_chk;
  int   n_err;
  logic m_ie;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  punc_mmio_console_if bus();

  punc_mmio_console #(.KB_FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic m_hit(input logic [15:0] a);
    return (a == A_KBSR) || (a == A_KBDR) || (a == A_DSR) || (a == A_DDR);
  endfunction

  // Console as the programmer sees it while the display is idle.
  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a == A_KBSR) return {(q.size() != 0), m_ie, 14'b0};
    if (a == A_KBDR) return (q.size() != 0) ? {8'h00, q[0]} : 16'h0000;
    if (a == A_DSR)  return 16'h8000;
    return 16'h0000;
  endfunction

  task automatic fstep(input string tag, input logic [15:0] a, input logic en,
                       input logic v, input logic [7:0] d);
    logic pop_ok, push_ok;
    bus.r_addr = a; bus.rd_en = en; bus.kb_valid = v; bus.kb_data = d;
    #1;
    chk({tag, "_rdata"}, bus.r_data, m_read(a));
    chk({tag, "_hit"}, {15'b0, bus.hit_r}, {15'b0, m_hit(a)});
    chk({tag, "_kbrdy"}, {15'b0, bus.kb_ready}, {15'b0, (q.size() < DEPTH)});
    pop_ok  = en && (a == A_KBDR) && (q.size() != 0);
    push_ok = v && (q.size() < DEPTH);
    tick();
    if (pop_ok)  void'(q.pop_front());
    if (push_ok) q.push_back(d);
    bus.rd_en = 1'b0; bus.kb_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] wd, input logic second);
    logic [9:0] bits;
    logic exp_tx;
    bits = {1'b1, wd[7:0], 1'b0};
    bus.w_en = 1'b1; bus.w_addr = A_DDR; bus.w_data = wd; bus.r_addr = A_DSR;
    #1;
    chk("dsr_same_cycle", bus.r_data, 16'h8000);
    chk("tx_before_frame", {15'b0, bus.tx}, 16'h0001);
    tick();
    bus.w_en = 1'b0;
    for (int i = 1; i <= 10*CPB + 5; i++) begin
      if (second && i == 10) begin
        bus.w_en = 1'b1; bus.w_addr = A_DDR; bus.w_data = 16'h00AA;
      end
      #1;
      exp_tx = (i <= 10*CPB) ? bits[(i-1)/CPB] : 1'b1;
      chk("frame_tx", {15'b0, bus.tx}, {15'b0, exp_tx});
      chk("frame_dsr", bus.r_data, (i <= 10*CPB) ? 16'h0000 : 16'h8000);
      tick();
      bus.w_en = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; m_ie = 1'b0;
    rst = 1'b1;
    bus.r_addr = '0; bus.rd_en = 1'b0; bus.w_addr = '0; bus.w_data = '0; bus.w_en = 1'b0;
    bus.kb_valid = 1'b0; bus.kb_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_kbrdy", {15'b0, bus.kb_ready}, 16'h0001);
    chk("rst_tx", {15'b0, bus.tx}, 16'h0001);
    chk("rst_irq", {15'b0, bus.irq}, 16'h0000);

    fstep("rd_kbsr", A_KBSR, 1'b0, 1'b0, 8'h00);
    fstep("rd_kbdr", A_KBDR, 1'b0, 1'b0, 8'h00);
    fstep("rd_dsr",  A_DSR,  1'b0, 1'b0, 8'h00);
    fstep("rd_ddr",  A_DDR,  1'b0, 1'b0, 8'h00);
    fstep("rd_miss", 16'h3000, 1'b0, 1'b0, 8'h00);

    fstep("push41", 16'h3000, 1'b0, 1'b1, 8'h41);
    fstep("push42", 16'h3000, 1'b0, 1'b1, 8'h42);
    fstep("kbsr_ne", A_KBSR, 1'b0, 1'b0, 8'h00);
    fstep("peek_noen", A_KBDR, 1'b0, 1'b0, 8'h00);
    fstep("pop41", A_KBDR, 1'b1, 1'b0, 8'h00);
    fstep("pop42", A_KBDR, 1'b1, 1'b0, 8'h00);
    fstep("kbsr_e", A_KBSR, 1'b0, 1'b0, 8'h00);
    fstep("pop_empty", A_KBDR, 1'b1, 1'b0, 8'h00);
    fstep("after_empty", A_KBSR, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < DEPTH; i++) fstep("fill", 16'h3000, 1'b0, 1'b1, 8'hA0 + 8'(i));
    fstep("full_hold0", A_KBSR, 1'b0, 1'b1, 8'hEE);
    fstep("full_hold1", A_KBDR, 1'b0, 1'b1, 8'hEE);
    fstep("pop_to3", A_KBDR, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) fstep("popush", A_KBDR, 1'b1, 1'b1, 8'hB0 + 8'(i));
    for (int i = 0; i < 6; i++) fstep("drain", A_KBDR, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 5))
        0: a = A_KBSR;
        1, 2: a = A_KBDR;
        3: a = A_DSR;
        4: a = A_DDR;
        default: a = 16'($urandom);
      endcase
      fstep("rnd", a, 1'($urandom), 1'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 6; i++) fstep("drain2", A_KBDR, 1'b1, 1'b0, 8'h00);

    frame(16'h1255, 1'b1);
    frame({8'($urandom), 8'($urandom)}, 1'b0);

    fstep("pre_rst_push", 16'h3000, 1'b0, 1'b1, 8'h5A);
    bus.w_en = 1'b1; bus.w_addr = A_DDR; bus.w_data = 16'h00F0; bus.r_addr = A_DSR;
    tick();
    bus.w_en = 1'b0;
    repeat (17) tick();
    #1;
    chk("mid_bit3_tx", {15'b0, bus.tx}, 16'h0000);
    rst = 1'b1;
    tick();
    #1;
    chk("rst_mid_tx", {15'b0, bus.tx}, 16'h0001);
    chk("rst_mid_dsr", bus.r_data, 16'h8000);
    rst = 1'b0;
    q.delete();
    fstep("rst_mid_kbsr", A_KBSR, 1'b0, 1'b0, 8'h00);

    bus.w_en = 1'b1; bus.w_addr = A_KBSR; bus.w_data = 16'h4000;
    tick();
    bus.w_en = 1'b0;
`ifdef PUNC_CONSOLE_IRQ_EN
    m_ie = 1'b1;
`endif
    fstep("ie_rd", A_KBSR, 1'b0, 1'b0, 8'h00);
    fstep("push0d", 16'h3000, 1'b0, 1'b1, 8'h0D);
    tick();
    #1;
`ifdef PUNC_CONSOLE_IRQ_EN
    chk("irq_rise", {15'b0, bus.irq}, 16'h0001);
`else
    chk("irq_tied", {15'b0, bus.irq}, 16'h0000);
`endif
    fstep("kbsr_irq", A_KBSR, 1'b0, 1'b0, 8'h00);
    fstep("pop0d", A_KBDR, 1'b1, 1'b0, 8'h00);
    tick();
    #1;
    chk("irq_fall", {15'b0, bus.irq}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/punc_mmio_console.md
Name: punc_mmio_console

Overview:
- Memory-mapped console responder answering the LC3 datapath's load/store accesses at the standard device addresses: KBSR, KBDR, DSR, DDR.
- Sits beside the 1024-entry main memory on the same read/write address buses; the datapath selects its read data whenever hit_r is high.
- Keyboard bytes arrive through a valid/ready input into a small FIFO; display bytes leave as 8N1 serial on tx.

Parameters:
- KBSR_ADDR, 16'hFE00, keyboard status register address
- KBDR_ADDR, 16'hFE02, keyboard data register address
- DSR_ADDR, 16'hFE04, display status register address
- DDR_ADDR, 16'hFE06, display data register address
- KB_FIFO_DEPTH, 4, keyboard FIFO entries; power of 2, minimum 2
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r_addr  in  16  read address, same net that drives the memory read port 0
- rd_en  in  1  qualifies r_addr as a real load; required for KBDR pop side effect
- r_data  out  16  combinational read data
- hit_r  out  1  r_addr matches one of the four device addresses
- w_addr  in  16  write address
- w_data  in  16  write data
- w_en  in  1  write strobe
- kb_valid  in  1  keyboard byte offered
- kb_data  in  8  keyboard byte
- kb_ready  out  1  FIFO not full
- tx  out  1  serial output; idle high
- irq  out  1  keyboard interrupt request (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: FIFO empty, kb_ready=1, tx=1, TX FSM IDLE, DSR ready=1, KBSR IE=0, irq=0.
- Reads: combinational, same cycle.
  - KBSR = {!empty, IE, 14'b0}.
  - KBDR = {8'b0, FIFO head}; reads 16'h0000 when empty.
  - DSR = {tx_idle, 15'b0}.
  - DDR reads 16'h0000.
  - A non-matching address gives r_data=0 and hit_r=0.
- KBDR pop: occurs at the edge where rd_en=1, r_addr=KBDR_ADDR and the FIFO is not empty. Empty pop is ignored. A read without rd_en has no side effect.
- Push: occurs at the edge where kb_valid && kb_ready. Pop and push in the same cycle are both honoured, so the count is unchanged. When full, kb_ready=0 and kb_data is not accepted.
- FIFO pointers wrap modulo KB_FIFO_DEPTH. The count is log2(DEPTH)+1 bits wide.
- DDR write: w_en=1, w_addr=DDR_ADDR, DSR ready=1. w_data[7:0] is latched; w_data[15:8] is ignored. DSR ready=0 from the next cycle. A DDR write while not ready is dropped silently.
- TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, 3-bit bit index.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - Baud counter reloads at every bit boundary.
  - START begins the cycle after the accepted write.
  - DSR ready returns to 1 in the first cycle after STOP completes: 10*CLKS_PER_BIT+1 cycles after the write edge.
- A write and a read of DSR in the same cycle: the read returns the pre-write value (1).
- Writes to KBSR update only bit 14 (IE) when the feature is compiled. All other writes to device addresses are ignored. Writes are not qualified by address hit elsewhere; the datapath/controller is responsible for not also writing main memory.
- Reset mid-frame: tx is forced to 1 and the FSM returns to IDLE at the reset edge. The FIFO contents are discarded.

Optional Feature:
- Macro: PUNC_CONSOLE_IRQ_EN.
- Defined:
  - KBSR[14] is a writable IE bit, reset 0.
  - irq is registered: irq = IE && !empty, updated each edge, so it rises one cycle after the push that makes the FIFO non-empty.
- Undefined:
  - KBSR[14] reads 0 and writes to it are ignored.
  - irq is tied 0.

Decomposition:
- Shared package/defines: the four device address constants, TX state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), and the KBSR/DSR bit positions (READY=15, IE=14).
- Sub-module punc_uart_tx:
  - Inputs: clk, rst, start, byte.
  - Outputs: tx, idle.
  - Parameter: CLKS_PER_BIT.
- The FIFO stays inline in the top.

Test Plan:
- Reset, then read each of FE00/FE02/FE04/FE06 -> r_data = 0000/0000/8000/0000, hit_r=1. Read 3000 -> hit_r=0, r_data=0000.
- Push 8'h41, then 8'h42; read KBSR -> 8000. Read KBDR with rd_en -> 0041. Read again -> 0042. Read KBSR -> 0000. Extra KBDR pop while empty -> 0000, no underflow.
- Push 4 bytes -> kb_ready=0; 5th byte held on kb_valid is not accepted. Pop and push simultaneously while at depth 3 -> count stays 3, order preserved across pointer wrap.
- With CLKS_PER_BIT=4, write DDR=16'h1255:
  - DSR=0 next cycle.
  - tx sequence: 0, 1,0,1,0,1,0,1,0, 1, each 4 cycles.
  - DSR=8000 at write+41 cycles.
  - A second DDR write during the frame is dropped.
- Assert rst during DATA bit 3 -> tx=1 and DSR=8000 the cycle after; FIFO empty.
- With PUNC_CONSOLE_IRQ_EN defined: write KBSR=4000, then push 8'h0D -> irq=1 one cycle later. Pop -> irq=0 the cycle after. Without the macro: KBSR reads 8000 after the push and irq stays 0.
